// File: rtl/conv3x3_sched.sv
// conv3x3_sched: output-position / input-channel sequencer for the 3x3
// multi-channel convolution datapath.
//
// The sequencer walks every output position of one filter pass in raster
// order. For each position it issues one window fetch per input channel. The
// channel-phase code and data-valid go through an RD_LAT-deep delay line so
// they reach the datapath together with the returned window. The sequencer
// also writes the datapath results to sequential output-buffer addresses.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle pulse, starts a pass when idle
//   busy, done, err    pass in progress / end-of-pass pulse / sticky error:
//                      a result arrived when none was expected
//   win_valid/ready    window fetch handshake
//   win_row/col/ch     top-left window coordinate and input channel
//   dp_valid, dp_ch    datapath data-valid and channel phase
//                      (01 first, 11 middle, 10 last, 00 idle)
//   res_valid          datapath result strobe
//   out_we, out_addr   output-buffer write
//   dbg_state          current FSM state (0 idle, 1 issue, 2 drain)
//
// Handshake: a fetch transfers on every rising edge where win_valid and
// win_ready are both high. While win_valid is high and win_ready is low,
// win_row/win_col/win_ch hold steady. The sequencer never withdraws
// win_valid in the middle of a pass.

module conv3x3_sched #(
  parameter int IN_CH  = 3,
  parameter int IMG_W  = 224,
  parameter int STRIDE = 2,
  parameter int OUT_W  = 111,
  parameter int RD_LAT = 1,
  parameter int AW     = 9,
  parameter int OAW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           win_valid,
  input  logic           win_ready,
  output logic [AW-1:0]  win_row,
  output logic [AW-1:0]  win_col,
  output logic [1:0]     win_ch,
  output logic           dp_valid,
  output logic [1:0]     dp_ch,
  input  logic           res_valid,
  output logic           out_we,
  output logic [OAW-1:0] out_addr,
  output logic [1:0]     dbg_state
);

  if ((OUT_W != (IMG_W - 3) / STRIDE + 1) || (IN_CH < 2) || (RD_LAT < 1)) begin : g_cfg_check
    $error("conv3x3_sched: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // The result counter is one bit wider than the address so that it can
  // represent the full count OUT_W*OUT_W.
  localparam int            CW       = OAW + 1;
  localparam logic [1:0]    CH_LAST  = 2'(IN_CH - 1);
  localparam logic [AW-1:0] POS_LAST = AW'(OUT_W - 1);
  localparam logic [AW-1:0] STEP     = AW'(STRIDE);
  localparam logic [CW-1:0] TOTAL    = CW'(OUT_W * OUT_W);
  localparam logic [CW-1:0] TOTAL_M1 = CW'(OUT_W * OUT_W - 1);

  state_t          r_state, w_next;
  logic [1:0]      r_ch;
  logic [AW-1:0]   r_ocol, r_orow;
  logic [AW-1:0]   r_col, r_row;
  logic [CW-1:0]   r_cnt;
  logic            r_out_we, r_done, r_err;
  logic [OAW-1:0]  r_out_addr;
  logic [RD_LAT-1:0] r_dl_v;
  logic [1:0]      r_dl_ph [RD_LAT];

  logic w_start, w_accept, w_ch_last, w_col_last, w_row_last, w_last_beat;
  logic w_res_ok;
  logic [1:0] w_phase;

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_accept    = (r_state == S_ISSUE) && win_ready;
  assign w_ch_last   = (r_ch == CH_LAST);
  assign w_col_last  = (r_ocol == POS_LAST);
  assign w_row_last  = (r_orow == POS_LAST);
  assign w_last_beat = w_accept && w_ch_last && w_col_last && w_row_last;
  // A result is accepted only while a pass is running and slots remain.
  assign w_res_ok    = res_valid && (r_state != S_IDLE) && (r_cnt != TOTAL);

  always_comb begin
    w_phase = 2'b11;
    if (r_ch == 2'd0)      w_phase = 2'b01;
    else if (w_ch_last)    w_phase = 2'b10;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (w_last_beat) w_next = S_DRAIN;
      // The count reaches TOTAL in the cycle of the final write and done.
      // The FSM therefore leaves one cycle after done.
      S_DRAIN: if (r_cnt == TOTAL) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_ocol     <= '0;
      r_orow     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_ch   <= '0;
        r_ocol <= '0;
        r_orow <= '0;
        r_col  <= '0;
        r_row  <= '0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        // Channel is the innermost loop, then column, then row. The
        // coordinates step by STRIDE alongside the indices, so no
        // multiplier is needed. After the final beat the counters wrap to 0.
        if (w_ch_last) begin
          r_ch <= '0;
          if (w_col_last) begin
            r_ocol <= '0;
            r_col  <= '0;
            if (w_row_last) begin
              r_orow <= '0;
              r_row  <= '0;
            end else begin
              r_orow <= r_orow + 1'b1;
              r_row  <= r_row + STEP;
            end
          end else begin
            r_ocol <= r_ocol + 1'b1;
            r_col  <= r_col + STEP;
          end
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end

      r_out_we <= w_res_ok;
      r_done   <= w_res_ok && (r_cnt == TOTAL_M1);
      if (w_res_ok) begin
        r_out_addr <= r_cnt[OAW-1:0];
        r_cnt      <= r_cnt + 1'b1;
      end

      // If an unexpected result arrives in the same cycle as start, the
      // error is flagged.
      if (res_valid && !w_res_ok) r_err <= 1'b1;
      else if (w_start)           r_err <= 1'b0;
    end
  end

  // Delay line for {valid, phase}. A cycle without an accepted beat pushes
  // a bubble. dp_ch is therefore 00 whenever dp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_v <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dl_ph[i] <= 2'b00;
    end else begin
      r_dl_v[0]  <= w_accept;
      r_dl_ph[0] <= w_accept ? w_phase : 2'b00;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dl_v[i]  <= r_dl_v[i-1];
        r_dl_ph[i] <= r_dl_ph[i-1];
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign win_valid = (r_state == S_ISSUE);
  assign win_row   = r_row;
  assign win_col   = r_col;
  assign win_ch    = r_ch;
  assign dp_valid  = r_dl_v[RD_LAT-1];
  assign dp_ch     = r_dl_ph[RD_LAT-1];
  assign out_we    = r_out_we;
  assign out_addr  = r_out_addr;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
